zigzag_acc: RTL and testbench
=============================

ZIGZAG_ACC -- requirements
Module: zigzag_acc

Interface
REQ-001 SHALL have parameter BWPP, default 7, meaning the bitwidth of the unsigned popcount partial product.
REQ-002 SHALL have parameter BWOUT, default 24, meaning the bitwidth of the signed two's-complement result.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pw  input  4  weight precision, 1..8.
REQ-006 SHALL have port pd  input  4  data precision, 1..8.
REQ-007 SHALL have port sw  input  1  weights signed when 1.
REQ-008 SHALL have port sd  input  1  data signed when 1.
REQ-009 SHALL have port in_valid  input  1  a partial-product beat is presented.
REQ-010 SHALL have port in_ready  output  1  the block accepts the beat.
REQ-011 SHALL have port in_offw  input  4  weight bit offset of the beat, 0 = MSB.
REQ-012 SHALL have port in_offd  input  4  data bit offset of the beat, 0 = MSB.
REQ-013 SHALL have port in_eod  input  1  the beat is the last one of its diagonal.
REQ-014 SHALL have port in_pp  input  BWPP  unsigned popcount for (in_offw, in_offd).
REQ-015 SHALL have port out_valid  output  1  a result is held.
REQ-016 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-017 SHALL have port out_data  output  BWOUT  signed product result.

Function
REQ-018 A beat SHALL be accepted when in_valid & in_ready are both 1 on a rising edge; nothing else SHALL change diagonal or result state.
REQ-019 The term SHALL be -in_pp when (sw & in_offw==0) XOR (sd & in_offd==0); otherwise it SHALL be +in_pp (sign-extended).
REQ-020 On an accepted beat with in_eod=0, the diagonal sum SHALL be updated to dsum + term.
REQ-021 On an accepted beat with in_eod=1, acc SHALL become (acc<<1) + dsum + term, dsum SHALL clear, and the diagonal count SHALL increment.
REQ-022 Precision inputs SHALL be sampled on the first beat of a product; pw=0 or pd=0 SHALL be treated as 1.
REQ-023 The product SHALL be complete when the diagonal count reaches pw+pd-1; that final value of acc SHALL be loaded into out_data.
REQ-024 out_valid SHALL be 1 in the cycle after the final beat; acc, dsum and the count SHALL be 0 in that same cycle.
REQ-025 in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally.
REQ-026 A final beat accepted while out_ready=1 and out_valid=1 SHALL load the new result, and out_valid SHALL stay 1.
REQ-027 out_valid SHALL clear on out_valid & out_ready unless REQ-026 applies.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Arithmetic SHALL be signed with no saturation; the value range is |result| <= 2^(BWPP-1) * 2^16, so it fits in BWOUT=24.
REQ-030 The block SHALL have two states, ACC and HOLD (out_valid); HOLD SHALL not block accumulation except through REQ-025.

Reset
REQ-031 While clr_n=0 at a rising edge, the block SHALL set acc, dsum, the diagonal count, out_valid and out_data to 0 and return to state ACC; this SHALL override any beat presented in the same cycle.
REQ-032 Reset asserted mid-product SHALL discard partial state; the next beat after reset SHALL start a new product.

Structure
REQ-033 A shared package SHALL hold BWPP, BWOUT, the precision width (4) and the term-sign function.
REQ-034 The block SHALL contain one sub-module, zigzag_acc_term, which maps (in_pp, in_offw, in_offd, sw, sd) to the signed term combinationally.

Verification
REQ-035 The bench SHALL cover: pw=pd=1, unsigned, one beat pp=5 with eod -> out_valid next cycle, out_data=5.
REQ-036 The bench SHALL cover: pw=pd=2, unsigned, beats (0,0)pp=1 eod; (0,1)pp=2; (1,0)pp=3 eod; (1,1)pp=4 eod -> out_data=18.
REQ-037 The bench SHALL cover: the same beats with sw=sd=1 -> terms +1,-2,-3,+4 -> out_data=-2 (0xFFFFFE).
REQ-038 The bench SHALL cover: out_ready=0 with a result held -> in_ready=0; the second product's beats stall; out_ready=1 -> the first result is taken, the second result follows, and no beat is lost.
REQ-039 The bench SHALL cover: clr_n=0 after 2 beats of a pw=pd=2 product -> all outputs 0; a subsequent unsigned pw=pd=1 pp=7 -> out_data=7.
REQ-040 The bench SHALL cover: a final beat accepted while a result is handshaken in the same cycle -> out_valid stays 1 and out_data holds the new value.

Source files
------------

// File: rtl/zigzag_acc_pkg.sv
// Shared widths, FSM state type and the term-sign rule for the zigzag accumulator.
// Pure declarations: no logic, no latency, no flow control.
package zigzag_acc_pkg;

    localparam int BWPP_DEF  = 7;
    localparam int BWOUT_DEF = 24;
    localparam int PREC_W    = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // The MSB plane (offset 0) of a signed operand carries negative weight.
    function automatic logic term_neg(
        input logic              sw,
        input logic              sd,
        input logic [PREC_W-1:0] offw,
        input logic [PREC_W-1:0] offd
    );
        return (sw && (offw == '0)) ^ (sd && (offd == '0));
    endfunction

endpackage

// File: rtl/zigzag_acc_term.sv
// Maps one unsigned popcount beat to its signed contribution.
// Purely combinational; no latency and no flow control.
module zigzag_acc_term
    import zigzag_acc_pkg::*;
#(
    parameter int BWPP = BWPP_DEF
) (
    input  logic [BWPP-1:0]     pp,
    input  logic [PREC_W-1:0]   offw,
    input  logic [PREC_W-1:0]   offd,
    input  logic                sw,
    input  logic                sd,
    output logic signed [BWPP:0] term
);

    logic signed [BWPP:0] pp_s;

    always_comb begin
        pp_s = $signed({1'b0, pp});
        term = term_neg(sw, sd, offw, offd) ? -pp_s : pp_s;
    end

endmodule

// File: rtl/zigzag_acc.sv
// Bit-serial zigzag product accumulator: diagonals are summed, then shifted into acc.
// Result is valid the cycle after the final beat; a held, unconsumed result stalls in_ready.
module zigzag_acc
    import zigzag_acc_pkg::*;
#(
    parameter int BWPP  = BWPP_DEF,
    parameter int BWOUT = BWOUT_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [3:0]        pw,
    input  logic [3:0]        pd,
    input  logic              sw,
    input  logic              sd,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_offw,
    input  logic [3:0]        in_offd,
    input  logic              in_eod,
    input  logic [BWPP-1:0]   in_pp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BWOUT-1:0]  out_data
);

    localparam logic [PREC_W:0] CNT_ONE = 1;

    state_t                   state, state_nxt;
    logic signed [BWOUT-1:0]  acc, dsum, acc_nxt, term_x, res_q;
    logic signed [BWPP:0]     term;
    logic [PREC_W:0]          cnt, ndiag_q, ndiag_in, ndiag_cur;
    logic [PREC_W-1:0]        pw_eff, pd_eff;
    logic                     started, beat, last_beat;

    zigzag_acc_term #(.BWPP(BWPP)) u_term (
        .pp   (in_pp),
        .offw (in_offw),
        .offd (in_offd),
        .sw   (sw),
        .sd   (sd),
        .term (term)
    );

    always_comb begin
        pw_eff    = (pw == '0) ? 4'd1 : pw;
        pd_eff    = (pd == '0) ? 4'd1 : pd;
        ndiag_in  = {1'b0, pw_eff} + {1'b0, pd_eff} - CNT_ONE;
        // The first beat of a product must already see its own diagonal count.
        ndiag_cur = started ? ndiag_q : ndiag_in;
        term_x    = {{(BWOUT-BWPP-1){term[BWPP]}}, term};
        acc_nxt   = (acc <<< 1) + dsum + term_x;
        out_valid = (state == ST_HOLD);
        in_ready  = !(out_valid && !out_ready);
        beat      = in_valid && in_ready;
        last_beat = beat && in_eod && ((cnt + CNT_ONE) == ndiag_cur);
        out_data  = res_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (last_beat) state_nxt = ST_HOLD;
            ST_HOLD: if (!last_beat && out_ready) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state   <= ST_ACC;
            acc     <= '0;
            dsum    <= '0;
            cnt     <= '0;
            ndiag_q <= '0;
            started <= 1'b0;
            res_q   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                if (!started) ndiag_q <= ndiag_in;
                if (last_beat) begin
                    res_q   <= acc_nxt;
                    acc     <= '0;
                    dsum    <= '0;
                    cnt     <= '0;
                    started <= 1'b0;
                end else if (in_eod) begin
                    acc     <= acc_nxt;
                    dsum    <= '0;
                    cnt     <= cnt + CNT_ONE;
                    started <= 1'b1;
                end else begin
                    dsum    <= dsum + term_x;
                    started <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zigzag_acc.sv
// Self-checking bench for zigzag_acc: scoreboard of expected products plus per-scenario checks.
module tb_zigzag_acc;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  pw, pd;
    logic        sw, sd;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_offw, in_offd;
    logic        in_eod;
    logic [6:0]  in_pp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];
    logic [23:0] sb_exp;

    zigzag_acc dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .pw        (pw),
        .pd        (pd),
        .sw        (sw),
        .sd        (sd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_offw   (in_offw),
        .in_offd   (in_offd),
        .in_eod    (in_eod),
        .in_pp     (in_pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: a handshake at the coming rising edge must deliver the oldest expected result.
    always @(negedge clk) begin
        if (clr_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got out_data=%h, required no result", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out_data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got out_data=%h, required %h", out_data, sb_exp);
                end
            end
        end
    end

    // Starts and ends 1 time unit after a rising edge; returns once the beat is accepted.
    task automatic send_beat(input logic [3:0] offw, input logic [3:0] offd,
                             input logic eod, input logic [6:0] pp);
        int n = 0;
        in_valid = 1'b1;
        in_offw  = offw;
        in_offd  = offd;
        in_eod   = eod;
        in_pp    = pp;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: beat (%0d,%0d) not accepted, required acceptance", offw, offd);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_2x2(input logic [6:0] p00, input logic [6:0] p01,
                            input logic [6:0] p10, input logic [6:0] p11);
        send_beat(4'd0, 4'd0, 1'b1, p00);
        send_beat(4'd0, 4'd1, 1'b0, p01);
        send_beat(4'd1, 4'd0, 1'b1, p10);
        send_beat(4'd1, 4'd1, 1'b1, p11);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d out_valid=%b, required 0 and 0", name, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        pw = 4'd1; pd = 4'd1; sw = 1'b0; sd = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_offw = 4'd0; in_offd = 4'd0; in_eod = 1'b1; in_pp = 7'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h rdy=%b, required v=0 d=000000 rdy=1", out_valid, out_data, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_override: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_single();
        pw = 4'd1; pd = 4'd1; sw = 1'b0; sd = 1'b0;
        exp_q.push_back(24'd5);
        send_beat(4'd0, 4'd0, 1'b1, 7'd5);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd5) begin
            errors++;
            $display("FAIL single_latency: got v=%b d=%h, required v=1 d=000005", out_valid, out_data);
        end
        wait_drain("single");
    endtask

    task automatic test_unsigned_2x2();
        pw = 4'd2; pd = 4'd2; sw = 1'b0; sd = 1'b0;
        exp_q.push_back(24'd18);
        send_2x2(7'd1, 7'd2, 7'd3, 7'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd18) begin
            errors++;
            $display("FAIL unsigned_2x2: got v=%b d=%h, required v=1 d=000012", out_valid, out_data);
        end
        wait_drain("unsigned_2x2");
    endtask

    task automatic test_signed_2x2();
        pw = 4'd2; pd = 4'd2; sw = 1'b1; sd = 1'b1;
        exp_q.push_back(24'hFFFFFE);
        send_2x2(7'd1, 7'd2, 7'd3, 7'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'hFFFFFE) begin
            errors++;
            $display("FAIL signed_2x2: got v=%b d=%h, required v=1 d=fffffe", out_valid, out_data);
        end
        sw = 1'b0; sd = 1'b0;
        wait_drain("signed_2x2");
    endtask

    task automatic test_zero_precision();
        pw = 4'd0; pd = 4'd0; sw = 1'b0; sd = 1'b0;
        exp_q.push_back(24'd9);
        send_beat(4'd0, 4'd0, 1'b1, 7'd9);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd9) begin
            errors++;
            $display("FAIL zero_precision: got v=%b d=%h, required v=1 d=000009", out_valid, out_data);
        end
        wait_drain("zero_precision");
    endtask

    task automatic test_stall();
        pw = 4'd1; pd = 4'd1; sw = 1'b0; sd = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(24'd3);
        send_beat(4'd0, 4'd0, 1'b1, 7'd3);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
        end
        pw = 4'd2; pd = 4'd2;
        exp_q.push_back(24'd18);
        fork
            send_2x2(7'd1, 7'd2, 7'd3, 7'd4);
            begin
                repeat (4) @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1 || out_data !== 24'd3 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h rdy=%b, required v=1 d=000003 rdy=0", out_valid, out_data, in_ready);
                end
                out_ready = 1'b1;
            end
        join
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd18) begin
            errors++;
            $display("FAIL stall_second: got v=%b d=%h, required v=1 d=000012", out_valid, out_data);
        end
        wait_drain("stall");
    endtask

    task automatic test_mid_reset();
        pw = 4'd2; pd = 4'd2; sw = 1'b0; sd = 1'b0;
        send_beat(4'd0, 4'd0, 1'b1, 7'd1);
        send_beat(4'd0, 4'd1, 1'b0, 7'd2);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: got v=%b d=%h rdy=%b, required v=0 d=000000 rdy=1", out_valid, out_data, in_ready);
        end
        clr_n = 1'b1;
        pw = 4'd1; pd = 4'd1;
        exp_q.push_back(24'd7);
        send_beat(4'd0, 4'd0, 1'b1, 7'd7);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd7) begin
            errors++;
            $display("FAIL mid_reset_restart: got v=%b d=%h, required v=1 d=000007", out_valid, out_data);
        end
        wait_drain("mid_reset");
    endtask

    task automatic test_back_to_back();
        pw = 4'd1; pd = 4'd1; sw = 1'b0; sd = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(24'd2);
        exp_q.push_back(24'd6);
        send_beat(4'd0, 4'd0, 1'b1, 7'd2);
        send_beat(4'd0, 4'd0, 1'b1, 7'd6);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd6) begin
            errors++;
            $display("FAIL back_to_back: got v=%b d=%h, required v=1 d=000006", out_valid, out_data);
        end
        wait_drain("back_to_back");
    endtask

    initial begin
        in_valid = 1'b0;
        clr_n = 1'b0;
        test_reset();
        test_single();
        test_unsigned_2x2();
        test_signed_2x2();
        test_zero_precision();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
